// File: rtl/hdb3_pkg.sv
// hdb3_pkg: shared symbol codes and sizing constants for the HDB3 encoder.
//   sym_e     - 2-bit symbol class carried through the delay line
//   HDB3_RUN  - zero-run length that triggers a substitution
//   DLY       - depth of the symbol delay line
package hdb3_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_ONE  = 2'b01,
    SYM_B    = 2'b10,
    SYM_V    = 2'b11
  } sym_e;

  localparam int unsigned HDB3_RUN = 4;
  localparam int unsigned DLY      = 4;
  localparam int unsigned ZRUN_W   = $clog2(HDB3_RUN);
  localparam int unsigned FILL_W   = $clog2(DLY + 1);

endpackage

// File: rtl/hdb3_encoder_if.sv
// hdb3_encoder_if: bit-stream input and ternary rail output bundle.
//   i_data, i_en            - NRZ bit and its strobe (master drives)
//   o_pos, o_neg            - unipolar line rails
//   o_valid                 - rails carry a real encoded symbol
//   o_sym                   - debug symbol class of the emitted pulse
interface hdb3_encoder_if;
  import hdb3_pkg::*;

  logic i_data;
  logic i_en;
  logic o_pos;
  logic o_neg;
  logic o_valid;
  sym_e o_sym;

  modport master (output i_data, i_en, input o_pos, o_neg, o_valid, o_sym);
  modport slave  (input i_data, i_en, output o_pos, o_neg, o_valid, o_sym);

endinterface

// File: rtl/hdb3_polarity.sv
// hdb3_polarity: AMI polarity assignment for the symbol leaving the delay line.
//   i_clk, i_rst - clock, async active-high reset
//   i_sym        - symbol to emit (pre-shift tail of the delay line)
//   i_en         - enabled edge strobe; rails and o_sym clear when low
//   o_pos/o_neg  - registered rails, mutually exclusive
//   o_sym        - registered symbol class
module hdb3_polarity
  import hdb3_pkg::*;
#(
  parameter bit FIRST_POS = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  sym_e i_sym,
  input  logic i_en,
  output logic o_pos,
  output logic o_neg,
  output sym_e o_sym
);

  // lastpol: 1 = last pulse was positive
  logic lastpol_q, lastpol_d;
  logic pos_q, pos_d;
  logic neg_q, neg_d;
  sym_e sym_q, sym_d;

  // Marks and B pulses alternate; V repeats the previous polarity.
  always_comb begin
    lastpol_d = lastpol_q;
    pos_d     = 1'b0;
    neg_d     = 1'b0;
    sym_d     = SYM_ZERO;
    if (i_en) begin
      sym_d = i_sym;
      unique case (i_sym)
        SYM_ONE, SYM_B: begin
          pos_d     = ~lastpol_q;
          neg_d     = lastpol_q;
          lastpol_d = ~lastpol_q;
        end
        SYM_V: begin
          pos_d = lastpol_q;
          neg_d = ~lastpol_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lastpol_q <= ~FIRST_POS;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      sym_q     <= SYM_ZERO;
    end else begin
      lastpol_q <= lastpol_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      sym_q     <= sym_d;
    end
  end

  assign o_pos = pos_q;
  assign o_neg = neg_q;
  assign o_sym = sym_q;

endmodule

// File: rtl/hdb3_encoder.sv
// hdb3_encoder: streaming HDB3 line encoder with fixed DLY+1 enabled-edge latency.
//   i_clk, i_rst - clock, async active-high reset
//   bus (slave)  - i_data/i_en in; o_pos/o_neg/o_valid/o_sym out (all registered)
// Holds the zero-run counter, pulse parity, symbol delay line and fill/valid;
// polarity assignment lives in hdb3_polarity.
module hdb3_encoder
  import hdb3_pkg::*;
#(
  parameter bit FIRST_POS = 1'b1
) (
  input logic           i_clk,
  input logic           i_rst,
  hdb3_encoder_if.slave bus
);

  sym_e              sr_q [DLY];
  sym_e              sr_d [DLY];
  logic [ZRUN_W-1:0] zrun_q, zrun_d;
  logic              par_q, par_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              valid_q, valid_d;
  logic              subst;

  // Input stage: classify the bit, detect the 4th zero, shift the delay line.
  always_comb begin
    sr_d    = sr_q;
    zrun_d  = zrun_q;
    par_d   = par_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    subst   = 1'b0;
    if (bus.i_en) begin
      valid_d = (fill_q == FILL_W'(DLY));
      if (fill_q != FILL_W'(DLY)) begin
        fill_d = FILL_W'(fill_q + FILL_W'(1));
      end
      subst = !bus.i_data && (zrun_q == ZRUN_W'(HDB3_RUN - 1));
      for (int unsigned i = 1; i < DLY; i++) begin
        sr_d[i] = sr_q[i-1];
      end
      if (subst) begin
        sr_d[0] = SYM_V;
        // Even pulse count since last V: first zero of the run (entering the tail) becomes B.
        if (!par_q) begin
          sr_d[DLY-1] = SYM_B;
        end
        par_d  = 1'b0;
        zrun_d = '0;
      end else if (bus.i_data) begin
        sr_d[0] = SYM_ONE;
        par_d   = ~par_q;
        zrun_d  = '0;
      end else begin
        sr_d[0] = SYM_ZERO;
        zrun_d  = ZRUN_W'(zrun_q + ZRUN_W'(1));
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DLY; i++) begin
        sr_q[i] <= SYM_ZERO;
      end
      zrun_q  <= '0;
      par_q   <= 1'b0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      zrun_q  <= zrun_d;
      par_q   <= par_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  logic pol_pos;
  logic pol_neg;
  sym_e pol_sym;

  // Pre-shift tail of the delay line is the symbol emitted this edge.
  hdb3_polarity #(
    .FIRST_POS(FIRST_POS)
  ) u_polarity (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sym (sr_q[DLY-1]),
    .i_en  (bus.i_en),
    .o_pos (pol_pos),
    .o_neg (pol_neg),
    .o_sym (pol_sym)
  );

  assign bus.o_pos   = pol_pos;
  assign bus.o_neg   = pol_neg;
  assign bus.o_sym   = pol_sym;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_hdb3_encoder.sv
// tb_hdb3_encoder: table-driven scoreboard bench for hdb3_encoder (FIRST_POS=1).
// Line codes in the table: 0 none, p/n +/- mark, B/b +/- B pulse, V/v +/- V pulse.
module tb_hdb3_encoder;
  import hdb3_pkg::*;

  typedef struct packed {
    logic p;
    logic n;
    sym_e s;
  } exp_t;

  typedef struct {
    int   scen;
    logic d;
    exp_t e;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   mon_en;
  exp_t q[$];
  vec_t tbl[$];

  hdb3_encoder_if bus ();

  hdb3_encoder #(.FIRST_POS(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t tok(input byte c);
    exp_t e;
    case (c)
      "p":     e = '{p: 1'b1, n: 1'b0, s: SYM_ONE};
      "n":     e = '{p: 1'b0, n: 1'b1, s: SYM_ONE};
      "B":     e = '{p: 1'b1, n: 1'b0, s: SYM_B};
      "b":     e = '{p: 1'b0, n: 1'b1, s: SYM_B};
      "V":     e = '{p: 1'b1, n: 1'b0, s: SYM_V};
      "v":     e = '{p: 1'b0, n: 1'b1, s: SYM_V};
      default: e = '{p: 1'b0, n: 1'b0, s: SYM_ZERO};
    endcase
    return e;
  endfunction

  task automatic add_scen(input int sc, input string bits, input string line);
    vec_t v;
    for (int i = 0; i < bits.len(); i++) begin
      v.scen = sc;
      v.d    = (bits.getc(i) == "1");
      v.e    = tok(line.getc(i));
      tbl.push_back(v);
    end
  endtask

  task automatic check(input string name, input exp_t act, input logic act_v,
                       input exp_t exp, input logic exp_v);
    total++;
    if (act !== exp || act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got pos=%b neg=%b sym=%0d valid=%b, want pos=%b neg=%b sym=%0d valid=%b",
               name, act.p, act.n, act.s, act_v, exp.p, exp.n, exp.s, exp_v);
    end
  endtask

  function automatic exp_t outs();
    exp_t e;
    e.p = bus.o_pos;
    e.n = bus.o_neg;
    e.s = bus.o_sym;
    return e;
  endfunction

  // Inputs change 1 time unit after the active edge.
  task automatic drive(input logic d, input logic en);
    bus.i_data = d;
    bus.i_en   = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_en   = 1'b0;
    bus.i_data = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Streams one table scenario, optional idle gaps, then a flush of ones
  // (ones never rewrite earlier symbols) so every expected symbol is emitted.
  task automatic run_scen(input int sc, input int gap, input bit rst_first);
    if (rst_first) do_reset();
    q.delete();
    mon_en = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].scen == sc) begin
        q.push_back(tbl[i].e);
        drive(tbl[i].d, 1'b1);
        for (int g = 0; g < gap; g++) begin
          drive(1'b0, 1'b0);
          check($sformatf("idle_s%0d", sc), outs(), bus.o_valid, tok("0"), 1'b0);
        end
      end
    end
    repeat (DLY) drive(1'b1, 1'b1);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_s%0d: got %0d pending symbols, want 0", sc, q.size());
    end
    mon_en = 1'b0;
  endtask

  // Scoreboard: pop one expectation per valid output.
  always @(negedge clk) begin
    if (mon_en && bus.o_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_valid: got valid output pos=%b neg=%b, want none", bus.o_pos, bus.o_neg);
      end else begin
        check("stream", outs(), 1'b1, q.pop_front(), 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    string pre;
    total      = 0;
    bad        = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    bus.i_en   = 1'b0;
    bus.i_data = 1'b0;

    add_scen(1, "100001", "p000Vn");
    add_scen(2, "000000001", "B00Vb00vp");
    add_scen(3, "1100001", "pnB00Vn");
    add_scen(4, "1111111111111111", "pnpnpnpnpnpnpnpn");
    add_scen(6, "0000", "B00V");

    do_reset();
    check("reset_state", outs(), bus.o_valid, tok("0"), 1'b0);

    run_scen(1, 0, 1'b1);
    run_scen(2, 0, 1'b1);
    run_scen(3, 0, 1'b1);
    run_scen(4, 0, 1'b1);
    run_scen(1, 1, 1'b1);

    // Mid-stream async reset: 5 ones leave lastpol=+ and par=1, then a partial zero run.
    do_reset();
    pre = "1111100";
    for (int i = 0; i < pre.len(); i++) drive(pre.getc(i) == "1", 1'b1);
    check("pre_reset", outs(), bus.o_valid, tok("p"), 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), bus.o_valid, tok("0"), 1'b0);
    bus.i_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_scen(6, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdb3_encoder.md
# hdb3_encoder

Streaming HDB3 line encoder for the HDB3 test chain. It sits directly downstream of the serial pattern generator and consumes one NRZ data bit per enabled clock. It emits the ternary line code as two unipolar rails, positive and negative, for the decoder and checker stages. It performs zero-run substitution (000V / B00V) and AMI polarity assignment through a fixed-latency pipeline.

## Interface
Parameters:
- FIRST_POS, default 1: polarity of the first mark after reset. 1 means the first 1/B pulse is positive; internal last-polarity resets to negative.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- i_data  input  1  NRZ data bit, sampled on enabled edges
- i_en  input  1  bit strobe; an edge with i_en=1 is an "enabled edge"
- o_pos  output  1  positive-rail pulse, registered
- o_neg  output  1  negative-rail pulse, registered; never high together with o_pos
- o_valid  output  1  o_pos/o_neg carry a real encoded symbol this cycle
- o_sym  output  2  debug view of the emitted symbol class (ZERO/ONE/B/V)

## Operation
- Symbol classes are 2-bit codes: ZERO, ONE, B, V.
- Input stage, on each enabled edge:
  - The new symbol is ONE if i_data=1, otherwise ZERO.
  - zrun (0..3) counts consecutive input zeros. It clears on a 1 or on a substitution.
  - Substitution triggers when i_data=0 and zrun==3. The new symbol becomes V.
  - On substitution, if par==0 (even number of pulses since the last V), the symbol shifting into sr[3] is rewritten from ZERO to B.
  - On substitution, par clears and zrun clears.
  - When there is no substitution, each ONE toggles par.
- Delay line sr[0..3]: four symbols, shifted sr[0]<-new, sr[i]<-sr[i-1] on enabled edges only.
- Polarity stage (sub-module), capturing pre-shift sr[3] on each enabled edge:
  - ONE or B: drives polarity ~lastpol, then lastpol flips.
  - V: drives polarity lastpol; lastpol is unchanged.
  - ZERO: both rails low.
- fill counter (0..4, saturating) counts enabled edges. o_valid<=i_en && fill==4.
- Non-enabled edge: o_pos, o_neg and o_valid go to 0, o_sym goes to ZERO, all other state holds.
- Reset values:
  - sr all ZERO, zrun=0, par=0, fill=0.
  - lastpol = negative if FIRST_POS=1, else positive.
  - o_pos=0, o_neg=0, o_valid=0, o_sym=ZERO.

## Timing
- Latency: a bit sampled at enabled edge k appears on the outputs after enabled edge k+4. It is held one cycle, or until the next edge if i_en drops.
- With i_en held at 1 from reset release, the first valid output follows the 5th edge.
- The B rewrite targets the bit sampled 3 enabled edges earlier. That bit is still inside the delay line, so no output is ever retracted.
- Eight or more consecutive zeros produce a V every 4 bits. The B/V choice follows par at each trigger.
- Asserting i_rst mid-stream clears outputs immediately, without waiting for a clock. Partial runs and parity are discarded, and the stream restarts as if fresh.
- Deasserting i_en mid-stream does not break zero runs or parity. Encoding is a function of the enabled-bit sequence only.
- o_pos and o_neg are never both 1. Property: !(o_pos && o_neg) in every cycle.

## Structure
- Package hdb3_pkg holds:
  - symbol codes SYM_ZERO=2'b00, SYM_ONE=2'b01, SYM_B=2'b10, SYM_V=2'b11
  - the substitution run length constant HDB3_RUN=4
  - the delay depth DLY=4
- Sub-module hdb3_polarity:
  - owns lastpol and the registered o_pos/o_neg/o_sym
  - inputs are the symbol and the enable
- hdb3_encoder top holds the zero-run counter, parity, delay line and fill/valid.

## Test plan
- Reset, i_en=1, FIRST_POS=1. Stream 1,0,0,0,0,1 then 0s. Valid output: +,0,0,0,+(V),-.
- Reset, stream 0000 0000 then 1. Output: +(B),0,0,+(V), -(B),0,0,-(V), +.
- Reset, stream 1,1,0,0,0,0,1. Output: +,-,+(B),0,0,+(V),-.
- All-ones stream, 16 bits. Output alternates +,-,+,-…
- Stream 1,0,0,0,0,1 with one idle cycle (i_en=0) after each bit. During the idle cycle, o_valid=0 and both rails are 0. The valid output sequence equals the first scenario.
- Assert i_rst asynchronously mid-cycle during a zero run, then release and stream 0000. The outputs clear before the next edge. After refill the output is +(B),0,0,+(V), confirming par, zrun and lastpol were reset.
